// File: rtl/tqvp_spi_bus_bridge.sv
// SPI-slave (mode 0) to TinyQV peripheral-bus bridge: turns one SPI command frame
// into a single 32-bit register read or write on the peripheral bus.
module tqvp_spi_bus_bridge #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_cs_n,
   input  logic        spi_sclk,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic [5:0]  address,
   output logic [31:0] data_out,
   output logic [1:0]  data_write_n,
   output logic [1:0]  data_read_n,
   input  logic [31:0] data_in,
   input  logic        data_ready,
   output logic        busy,
   output logic        err_timeout,
   output logic [3:0]  dbg_state
);

   localparam logic [3:0] IDLE     = 4'd0;
   localparam logic [3:0] CMD      = 4'd1;
   localparam logic [3:0] WDATA    = 4'd2;
   localparam logic [3:0] WR_ISSUE = 4'd3;
   localparam logic [3:0] RD_ISSUE = 4'd4;
   localparam logic [3:0] RD_WAIT  = 4'd5;
   localparam logic [3:0] TURN     = 4'd6;
   localparam logic [3:0] RDATA    = 4'd7;
   localparam logic [3:0] DONE     = 4'd8;

   localparam int TW = $clog2(TIMEOUT + 1);

   // Bus words travel little-endian on the wire but each byte is sent MSB first.
   function automatic logic [31:0] f_swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   logic [1:0]    r_cs_sync;
   logic [1:0]    r_sclk_sync;
   logic [1:0]    r_mosi_sync;
   logic          r_cs_d;
   logic          r_sclk_d;

   logic [3:0]    r_state;
   logic [5:0]    r_bit_cnt;
   logic [31:0]   r_rx;
   logic [31:0]   r_tx;
   logic [TW-1:0] r_to_cnt;
   logic [5:0]    r_address;
   logic [31:0]   r_data_out;
   logic          r_miso;
   logic          r_err;

   logic          w_cs;
   logic          w_sclk;
   logic          w_mosi;
   logic          w_cs_fall;
   logic          w_sclk_rise;
   logic          w_sclk_fall;
   logic          w_bit_phase;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cs_sync   <= 2'b11;
         r_sclk_sync <= 2'b00;
         r_mosi_sync <= 2'b00;
         r_cs_d      <= 1'b1;
         r_sclk_d    <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[0], spi_cs_n};
         r_sclk_sync <= {r_sclk_sync[0], spi_sclk};
         r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
         r_cs_d      <= r_cs_sync[1];
         r_sclk_d    <= r_sclk_sync[1];
      end
   end

   assign w_cs        = r_cs_sync[1];
   assign w_sclk      = r_sclk_sync[1];
   assign w_mosi      = r_mosi_sync[1];
   assign w_cs_fall   = r_cs_d & ~w_cs;
   assign w_sclk_rise = w_sclk & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk & r_sclk_d;
   assign w_bit_phase = (r_state != IDLE) && (r_state != DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_bit_cnt  <= 6'd0;
         r_rx       <= 32'd0;
         r_tx       <= 32'd0;
         r_to_cnt   <= '0;
         r_address  <= 6'd0;
         r_data_out <= 32'd0;
         r_miso     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         // The bit counter keeps running through the read wait so the turnaround
         // byte stays aligned with the host while the bus access is in flight.
         if (w_sclk_rise && w_bit_phase) begin
            r_rx      <= {r_rx[30:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 6'd1;
         end

         if (r_state != RDATA) begin
            r_miso <= 1'b0;
         end else if (w_sclk_fall) begin
            r_miso <= r_tx[31];
            r_tx   <= {r_tx[30:0], 1'b0};
         end

         if ((r_state != IDLE) && w_cs) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_cs_fall) begin
                     r_state   <= CMD;
                     r_bit_cnt <= 6'd0;
                     r_err     <= 1'b0;
                  end
               end
               CMD: begin
                  if (w_sclk_rise && (r_bit_cnt == 6'd7)) begin
                     r_address <= {r_rx[4:0], w_mosi};
                     r_state   <= r_rx[6] ? RD_ISSUE : WDATA;
                  end
               end
               WDATA: begin
                  if (w_sclk_rise && (r_bit_cnt == 6'd39)) begin
                     r_data_out <= f_swap({r_rx[30:0], w_mosi});
                     r_state    <= WR_ISSUE;
                  end
               end
               WR_ISSUE: begin
                  r_state <= DONE;
               end
               // Read handshake: data_read_n stays 2'b10 (request valid) until data_ready
               // is sampled high (accepted) or TIMEOUT strobe cycles have elapsed.
               RD_ISSUE: begin
                  if (data_ready) begin
                     r_tx    <= f_swap(data_in);
                     r_state <= TURN;
                  end else begin
                     r_to_cnt <= TW'(1);
                     r_state  <= RD_WAIT;
                  end
               end
               RD_WAIT: begin
                  if (data_ready) begin
                     r_tx    <= f_swap(data_in);
                     r_state <= TURN;
                  end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                     r_tx    <= f_swap(ERR_DATA);
                     r_err   <= 1'b1;
                     r_state <= TURN;
                  end else begin
                     r_to_cnt <= r_to_cnt + TW'(1);
                  end
               end
               TURN: begin
                  if (w_sclk_rise && (r_bit_cnt == 6'd15)) begin
                     r_state <= RDATA;
                  end
               end
               RDATA: begin
                  if (w_sclk_rise && (r_bit_cnt == 6'd47)) begin
                     r_state <= DONE;
                  end
               end
               DONE: begin
                  r_state <= DONE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign data_write_n = (r_state == WR_ISSUE) ? 2'b10 : 2'b11;
   assign data_read_n  = ((r_state == RD_ISSUE) || (r_state == RD_WAIT)) ? 2'b10 : 2'b11;
   assign spi_miso     = r_miso;
   assign address      = r_address;
   assign data_out     = r_data_out;
   assign busy         = (r_state != IDLE);
   assign err_timeout  = r_err;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_tqvp_spi_bus_bridge.sv
// Bench for tqvp_spi_bus_bridge: an SPI host driver, a register-file peripheral with
// programmable read latency, and a scoreboard of expected bus transactions.
module tb_tqvp_spi_bus_bridge;

   localparam int H = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        spi_cs_n;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_miso;
   logic [5:0]  address;
   logic [31:0] data_out;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_in;
   logic        data_ready = 1'b0;
   logic        busy;
   logic        err_timeout;
   logic [3:0]  dbg_state;

   logic [39:0] exp_q[$];
   logic [39:0] wr_exp;
   logic [31:0] mem [64];
   int          n_cmp = 0;
   int          n_err = 0;
   int          wr_count = 0;
   int          rd_k = 0;
   int          rd_len = 0;
   int          rd_delay = 1000;
   bit          rd_tied = 1'b0;

   always #5 clk = ~clk;

   tqvp_spi_bus_bridge dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi_cs_n     (spi_cs_n),
      .spi_sclk     (spi_sclk),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso),
      .address      (address),
      .data_out     (data_out),
      .data_write_n (data_write_n),
      .data_read_n  (data_read_n),
      .data_in      (data_in),
      .data_ready   (data_ready),
      .busy         (busy),
      .err_timeout  (err_timeout),
      .dbg_state    (dbg_state)
   );

   assign data_in = mem[address];

   task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Peripheral model and bus monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (data_read_n == 2'b10) begin
         data_ready = rd_tied || (rd_k == rd_delay);
         rd_k++;
      end else begin
         if (rd_k != 0) rd_len = rd_k;
         rd_k = 0;
         data_ready = rd_tied;
      end
      if (data_write_n == 2'b10) begin
         wr_count++;
         mem[address] = data_out;
         if (exp_q.size() == 0) begin
            chk("wr_unexpected", {2'b01, address, data_out}, 40'h0);
         end else begin
            wr_exp = exp_q.pop_front();
            chk("wr_txn", {2'b01, address, data_out}, wr_exp);
         end
      end
      if ((data_write_n != 2'b11) && (data_read_n != 2'b11))
         chk("bus_excl", {36'h0, data_write_n, data_read_n}, 40'hF);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = tx[i];
         wait_clk(H);
         r[i] = spi_miso;
         spi_sclk = 1'b1;
         wait_clk(H);
         spi_sclk = 1'b0;
      end
      rx = r;
   endtask

   task automatic cs_begin();
      spi_cs_n = 1'b0;
      wait_clk(H);
   endtask

   task automatic cs_end();
      wait_clk(H);
      spi_cs_n = 1'b1;
      wait_clk(8);
   endtask

   task automatic spi_write(input logic [5:0] addr, input logic [31:0] data);
      logic [7:0] rx;
      exp_q.push_back({2'b01, addr, data});
      cs_begin();
      spi_byte({2'b00, addr}, rx);
      for (int b = 0; b < 4; b++) spi_byte(data[8*b +: 8], rx);
      cs_end();
   endtask

   task automatic spi_read(input logic [7:0] cmd, input logic [31:0] exp);
      logic [7:0]  rx;
      logic [31:0] got;
      logic [39:0] e;
      exp_q.push_back({2'b10, cmd[5:0], exp});
      cs_begin();
      spi_byte(cmd, rx);
      spi_byte(8'h00, rx);
      chk("turn_byte", {32'h0, rx}, 40'h0);
      for (int b = 0; b < 4; b++) begin
         spi_byte(8'h00, rx);
         got[8*b +: 8] = rx;
      end
      if (exp_q.size() == 0) begin
         chk("rd_unexpected", {2'b10, address, got}, 40'h0);
      end else begin
         e = exp_q.pop_front();
         chk("rd_txn", {2'b10, address, got}, e);
      end
      cs_end();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  rx;
      logic [5:0]  ra;
      logic [31:0] rd;
      rst_n = 1'b0;
      spi_cs_n = 1'b1;
      spi_sclk = 1'b0;
      spi_mosi = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom();
      mem[0] = 32'hCAFE_0042;
      mem[6'h28] = 32'h1357_9BDF;
      wait_clk(4);

      chk("rst_wr_n", {38'h0, data_write_n}, 40'h3);
      chk("rst_rd_n", {38'h0, data_read_n}, 40'h3);
      chk("rst_miso", {39'h0, spi_miso}, 40'h0);
      chk("rst_addr", {34'h0, address}, 40'h0);
      chk("rst_dout", {8'h0, data_out}, 40'h0);
      chk("rst_busy", {39'h0, busy}, 40'h0);
      chk("rst_err", {39'h0, err_timeout}, 40'h0);
      chk("rst_state", {36'h0, dbg_state}, 40'h0);
      rst_n = 1'b1;
      wait_clk(4);

      spi_write(6'h18, 32'h1234_5678);
      chk("wr_count_1", wr_count, 1);
      chk("busy_after_wr", {39'h0, busy}, 40'h0);

      rd_tied = 1'b1;
      spi_read(8'h80, 32'hCAFE_0042);
      chk("rd_len_zero_wait", rd_len, 1);
      rd_tied = 1'b0;

      rd_delay = 5;
      spi_read(8'hA8, 32'h1357_9BDF);
      chk("rd_len_wait5", rd_len, 6);
      chk("err_after_wait5", {39'h0, err_timeout}, 40'h0);

      rd_delay = 1000;
      spi_read(8'h83, 32'hDEAD_BEEF);
      chk("rd_len_timeout", rd_len, 16);
      chk("err_after_timeout", {39'h0, err_timeout}, 40'h1);
      spi_cs_n = 1'b0;
      wait_clk(H);
      chk("err_cleared_by_cs", {39'h0, err_timeout}, 40'h0);
      spi_cs_n = 1'b1;
      wait_clk(8);

      cs_begin();
      spi_byte(8'h05, rx);
      chk("busy_mid_frame", {39'h0, busy}, 40'h1);
      spi_byte(8'hAA, rx);
      spi_byte(8'h55, rx);
      cs_end();
      chk("busy_after_abort", {39'h0, busy}, 40'h0);
      chk("wr_count_abort", wr_count, 1);
      chk("state_after_abort", {36'h0, dbg_state}, 40'h0);
      spi_write(6'h05, 32'hA5A5_0F0F);
      chk("wr_count_after_abort", wr_count, 2);

      for (int n = 0; n < 3; n++) begin
         ra = 6'($urandom_range(0, 63));
         rd = $urandom();
         spi_write(ra, rd);
         rd_delay = $urandom_range(0, 8);
         spi_read({2'b10, ra}, rd);
         chk("rd_len_rand", rd_len, rd_delay + 1);
      end

      rd_delay = 1000;
      cs_begin();
      spi_byte(8'h85, rx);
      wait_clk(2);
      chk("rd_strobe_before_rst", {38'h0, data_read_n}, 40'h2);
      chk("state_rd_wait", {36'h0, dbg_state}, 40'h5);
      rst_n = 1'b0;
      wait_clk(1);
      chk("rst_mid_rd_n", {38'h0, data_read_n}, 40'h3);
      chk("rst_mid_miso", {39'h0, spi_miso}, 40'h0);
      chk("rst_mid_state", {36'h0, dbg_state}, 40'h0);
      rst_n = 1'b1;
      spi_cs_n = 1'b1;
      wait_clk(8);

      chk("wr_total", wr_count, 5);
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
